// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader for the accumulator CPU. A byte stream arrives
// over a valid/ready handshake in the form
//     LEN_H LEN_L { WORD_H WORD_L } x N  CHK
// Each pair of data bytes is assembled into a 16-bit instruction and written
// sequentially into instruction memory starting at address 0. The CPU is
// held in reset until the whole image has arrived and the XOR checksum
// matches. On a bad length or a bad checksum the loader parks in an error
// state and keeps the CPU in reset.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   in_valid  in_data holds a byte
//   in_data   stream byte
//   in_ready  loader can accept a byte (combinational from state)
//   wr_en     instruction memory write strobe, one cycle per word
//   wr_addr   instruction memory write address (held after the strobe)
//   wr_data   instruction word (held after the strobe)
//   cpu_rst   high while the CPU must be held in reset
//   done      image loaded and verified, CPU running
//   err       image rejected
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LEN_H,
        S_LEN_L,
        S_DAT_H,
        S_DAT_L,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    // Length limit widened by one bit so the comparison cannot wrap.
    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t            state;
    logic [15:0]       len;
    logic [7:0]        xor_acc;
    logic [7:0]        hi_byte;
    logic [ADDR_W:0]   idx;

    logic              accept;
    logic [15:0]       len_new;
    logic              len_ok;
    logic [15:0]       idx_ext;
    logic              last_word;

    assign in_ready = (state == S_LEN_H) || (state == S_LEN_L) ||
                      (state == S_DAT_H) || (state == S_DAT_L) ||
                      (state == S_CHK);

    assign accept = in_valid && in_ready;

    // Length check works on the full 16-bit value formed from the latched
    // high byte and the low byte currently on the bus.
    always_comb begin
        len_new   = {len[15:8], in_data};
        len_ok    = (len_new != 16'd0) && ({1'b0, len_new} <= MAX_LEN);
        idx_ext   = 16'(idx);
        last_word = (idx_ext == (len - 16'd1));
    end

    // Loader FSM. All outputs except in_ready are registered here; wr_en is
    // cleared every cycle so it can only ever pulse for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_LEN_H;
            len     <= '0;
            xor_acc <= '0;
            hi_byte <= '0;
            idx     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            cpu_rst <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                case (state)
                    S_LEN_H: begin
                        len     <= {in_data, 8'h00};
                        xor_acc <= xor_acc ^ in_data;
                        state   <= S_LEN_L;
                    end
                    S_LEN_L: begin
                        len     <= len_new;
                        xor_acc <= xor_acc ^ in_data;
                        if (len_ok) begin
                            state <= S_DAT_H;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                    S_DAT_H: begin
                        hi_byte <= in_data;
                        xor_acc <= xor_acc ^ in_data;
                        state   <= S_DAT_L;
                    end
                    S_DAT_L: begin
                        // Write uses the index before it is incremented.
                        wr_en   <= 1'b1;
                        wr_addr <= idx[ADDR_W-1:0];
                        wr_data <= {hi_byte, in_data};
                        xor_acc <= xor_acc ^ in_data;
                        idx     <= idx + 1'b1;
                        state   <= last_word ? S_CHK : S_DAT_H;
                    end
                    S_CHK: begin
                        // The checksum byte itself is not folded into xor_acc.
                        if (in_data == xor_acc) begin
                            state   <= S_RUN;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule
